// File: rtl/sgen_nco_fcw_est.sv
// Recovers the phase of a (sin, cos) sample pair with a vectoring CORDIC and estimates the
// NCO frequency control word as the wrapped phase step between successive samples.
module sgen_nco_fcw_est #(
  parameter int gp_rom_width        = 11,
  parameter int gp_phase_accu_width = 16,
  parameter int gp_iterations       = 14
) (
  input  logic                           i_clk,
  input  logic                           i_rst_a,
  input  logic                           i_ena,
  input  logic                           i_valid,
  input  logic [gp_rom_width:0]          i_sin,
  input  logic [gp_rom_width:0]          i_cos,
  output logic                           o_busy,
  output logic                           o_valid,
  output logic                           o_fcw_vld,
  output logic [gp_phase_accu_width-1:0] o_phase,
  output logic [gp_phase_accu_width-1:0] o_fcw,
  output logic                           o_ovf
);

  localparam int  W  = gp_phase_accu_width;
  localparam int  IT = gp_iterations;
  // Fractional guard bits under the sample LSB keep shift truncation noise below one phase LSB.
  localparam int  GB = 4;
  localparam int  XW = gp_rom_width + 3 + GB;
  localparam int  CW = $clog2(IT);
  localparam int  TW = 2 ** CW;
  localparam real PI = 3.14159265358979323846;

  function automatic logic [W-1:0] atan_lsb(input int i);
    real r;
    r = $atan(1.0 / (2.0 ** i)) / (2.0 * PI) * (2.0 ** W);
    return W'($rtoi(r + 0.5));
  endfunction

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_r;
  logic signed [XW-1:0] x_r;
  logic signed [XW-1:0] y_r;
  logic signed [XW-1:0] sin_ext_s;
  logic signed [XW-1:0] cos_ext_s;
  logic signed [XW-1:0] x_sh_s;
  logic signed [XW-1:0] y_sh_s;
  logic [W-1:0]         z_r;
  logic [W-1:0]         prev_phase_r;
  logic [W-1:0]         atan_cur_s;
  logic [W-1:0]         phase_s;
  logic [CW-1:0]        iter_r;
  logic                 prev_ok_r;
  logic                 zero_r;
  logic [W-1:0]         atan_s [TW];

  for (genvar g = 0; g < TW; g++) begin : g_atan
    if (g < IT) begin : g_used
      localparam logic [W-1:0] ATAN_C = atan_lsb(g);
      assign atan_s[g] = ATAN_C;
    end else begin : g_pad
      assign atan_s[g] = {W{1'b0}};
    end
  end

  assign sin_ext_s  = XW'($signed(i_sin)) <<< GB;
  assign cos_ext_s  = XW'($signed(i_cos)) <<< GB;
  assign x_sh_s     = x_r >>> iter_r;
  assign y_sh_s     = y_r >>> iter_r;
  assign atan_cur_s = atan_s[iter_r];
  assign phase_s    = zero_r ? {W{1'b0}} : z_r;

  // Sample accept, CORDIC micro-rotations, result publication and overflow tracking.
  always_ff @(posedge i_clk or posedge i_rst_a) begin
    if (i_rst_a) begin
      state_r      <= S_IDLE;
      x_r          <= {XW{1'b0}};
      y_r          <= {XW{1'b0}};
      z_r          <= {W{1'b0}};
      iter_r       <= {CW{1'b0}};
      zero_r       <= 1'b0;
      prev_phase_r <= {W{1'b0}};
      prev_ok_r    <= 1'b0;
      o_busy       <= 1'b0;
      o_valid      <= 1'b0;
      o_fcw_vld    <= 1'b0;
      o_phase      <= {W{1'b0}};
      o_fcw        <= {W{1'b0}};
      o_ovf        <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (i_valid && (state_r != S_IDLE)) begin
        o_ovf <= 1'b1;
      end
      if (!i_ena) begin
        state_r   <= S_IDLE;
        prev_ok_r <= 1'b0;
        o_busy    <= 1'b0;
      end else begin
        case (state_r)
          S_IDLE: begin
            if (i_valid) begin
              // Fold the left half-plane onto the right so the CORDIC range suffices.
              if (cos_ext_s < 0) begin
                x_r <= -cos_ext_s;
                y_r <= -sin_ext_s;
                z_r <= {1'b1, {(W-1){1'b0}}};
              end else begin
                x_r <= cos_ext_s;
                y_r <= sin_ext_s;
                z_r <= {W{1'b0}};
              end
              zero_r  <= (i_sin == {(gp_rom_width+1){1'b0}}) && (i_cos == {(gp_rom_width+1){1'b0}});
              iter_r  <= {CW{1'b0}};
              o_busy  <= 1'b1;
              state_r <= S_ITER;
            end
          end
          S_ITER: begin
            if (!y_r[XW-1]) begin
              x_r <= x_r + y_sh_s;
              y_r <= y_r - x_sh_s;
              z_r <= z_r + atan_cur_s;
            end else begin
              x_r <= x_r - y_sh_s;
              y_r <= y_r + x_sh_s;
              z_r <= z_r - atan_cur_s;
            end
            iter_r <= iter_r + 1'b1;
            if (iter_r == CW'(IT - 1)) begin
              state_r <= S_DONE;
            end
          end
          S_DONE: begin
            o_phase      <= phase_s;
            o_fcw        <= phase_s - prev_phase_r;
            o_fcw_vld    <= prev_ok_r;
            o_valid      <= 1'b1;
            prev_phase_r <= phase_s;
            prev_ok_r    <= 1'b1;
            o_busy       <= 1'b0;
            state_r      <= S_IDLE;
          end
          default: begin
            o_busy  <= 1'b0;
            state_r <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sgen_nco_fcw_est.sv
// Randomised scoreboard bench for sgen_nco_fcw_est: expected phase/fcw come from atan2 of the
// driven samples; a negedge monitor pops and compares whenever o_valid is presented.
module tb_sgen_nco_fcw_est;

  localparam int  RW  = 11;
  localparam int  W   = 16;
  localparam int  IT  = 14;
  localparam int  MOD = 65536;
  localparam real PI  = 3.14159265358979323846;

  logic          clk = 1'b0;
  logic          rst;
  logic          ena;
  logic          i_valid;
  logic [RW:0]   i_sin;
  logic [RW:0]   i_cos;
  logic          o_busy;
  logic          o_valid;
  logic          o_fcw_vld;
  logic [W-1:0]  o_phase;
  logic [W-1:0]  o_fcw;
  logic          o_ovf;

  always #5 clk = ~clk;

  sgen_nco_fcw_est #(
    .gp_rom_width(RW),
    .gp_phase_accu_width(W),
    .gp_iterations(IT)
  ) dut (
    .i_clk(clk),
    .i_rst_a(rst),
    .i_ena(ena),
    .i_valid(i_valid),
    .i_sin(i_sin),
    .i_cos(i_cos),
    .o_busy(o_busy),
    .o_valid(o_valid),
    .o_fcw_vld(o_fcw_vld),
    .o_phase(o_phase),
    .o_fcw(o_fcw),
    .o_ovf(o_ovf)
  );

  typedef struct {
    int     phase;
    int     fcw;
    int     prev;
    bit     vld;
    longint acc;
  } exp_t;

  exp_t   sb[$];
  longint cyc = 0;
  int     m_prev = 0;
  bit     m_ok = 1'b0;
  int     last_phase = 0;
  int     last_fcw = 0;
  int     n_chk = 0;
  int     n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wrapd(int d);
    int r;
    r = d & (MOD - 1);
    if (r >= MOD / 2) r -= MOD;
    return r;
  endfunction

  function automatic int rnd(real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    else return -$rtoi(-r + 0.5);
  endfunction

  function automatic int ref_phase(int s, int c);
    real a;
    if (s == 0 && c == 0) return 0;
    a = $atan2(real'(s), real'(c));
    if (a < 0.0) a += 2.0 * PI;
    return rnd(a / (2.0 * PI) * MOD) & (MOD - 1);
  endfunction

  task automatic chk_near(string name, int act, int expv, int tol);
    int d;
    n_chk++;
    d = wrapd(act - expv);
    if (d <= tol && d >= -tol) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, expv, tol);
  endtask

  task automatic chk_eq(string name, longint act, longint expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
  endtask

  // Monitor: every presented result is matched against the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && o_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_valid: got o_valid=1 at cycle %0d, expected no result pending", cyc);
      end else begin
        e = sb.pop_front();
        chk_eq("latency", cyc, e.acc + 15);
        chk_near("phase", int'(o_phase), e.phase, 4);
        chk_near("fcw", int'(o_fcw), e.fcw, 8);
        chk_eq("fcw_vld", o_fcw_vld, e.vld);
        last_phase = e.phase;
        last_fcw   = e.fcw;
      end
    end
  end

  // Drive one sample at a negedge while the DUT is idle; returns one negedge after acceptance.
  task automatic issue(int s, int c);
    exp_t e;
    int   p;
    p     = ref_phase(s, c);
    e.phase = p;
    e.prev  = m_prev;
    e.fcw   = (p - m_prev) & (MOD - 1);
    e.vld   = m_ok;
    e.acc   = cyc + 1;
    sb.push_back(e);
    m_prev  = p;
    m_ok    = 1'b1;
    i_sin   = (RW+1)'(s);
    i_cos   = (RW+1)'(c);
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    chk_eq("busy_after_accept", o_busy, 1);
  endtask

  task automatic send(int s, int c);
    issue(s, c);
    repeat (15) @(negedge clk);
  endtask

  // Forget the most recent in-flight sample, which the DUT abandoned.
  task automatic abandon_last();
    exp_t e;
    e = sb.pop_back();
    m_prev = e.prev;
    m_ok   = 1'b0;
  endtask

  task automatic send_random();
    real th;
    int  mag;
    th  = real'($urandom_range(65535, 0)) / MOD * 2.0 * PI;
    mag = $urandom_range(2047, 1024);
    send(rnd(mag * $sin(th)), rnd(mag * $cos(th)));
  endtask

  task automatic check_reset_state(string tag);
    chk_eq({tag, "_busy"}, o_busy, 0);
    chk_eq({tag, "_valid"}, o_valid, 0);
    chk_eq({tag, "_fcw_vld"}, o_fcw_vld, 0);
    chk_eq({tag, "_phase"}, o_phase, 0);
    chk_eq({tag, "_fcw"}, o_fcw, 0);
    chk_eq({tag, "_ovf"}, o_ovf, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int p;
    int fcws [2];
    rst = 1'b1; ena = 1'b1; i_valid = 1'b0; i_sin = '0; i_cos = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);

    // Zero phase, then the four quadrant points.
    send(0, 2047);
    send(2047, 0);
    send(0, -2047);
    send(-2047, 0);
    send(-2048, -2048);

    // NCO-style sequences, including one whose step wraps past 2*pi.
    fcws[0] = 1000;
    fcws[1] = 65000;
    foreach (fcws[k]) begin
      p = 0;
      for (int n = 0; n < 50; n++) begin
        send(rnd(2047.0 * $sin(2.0 * PI * p / MOD)), rnd(2047.0 * $cos(2.0 * PI * p / MOD)));
        p = (p + fcws[k]) % MOD;
      end
    end

    for (int n = 0; n < 30; n++) send_random();

    // Samples arriving while busy are dropped and latch o_ovf.
    chk_eq("ovf_clear_before", o_ovf, 0);
    issue(1500, -900);
    repeat (2) @(negedge clk);
    i_sin = 12'd100; i_cos = 12'd200; i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    chk_eq("ovf_after_iter_drop", o_ovf, 1);
    repeat (11) @(negedge clk);
    i_sin = 12'd300; i_cos = 12'd50; i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    send_random();
    chk_eq("ovf_sticky", o_ovf, 1);

    // Asynchronous reset in the middle of an iteration.
    issue(-1200, 1300);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_state("midreset");
    sb.delete();
    m_prev = 0; m_ok = 1'b0; last_phase = 0; last_fcw = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_random();
    send_random();

    // Enable dropped mid-iteration: no result, outputs hold, history invalidated.
    issue(900, 1700);
    repeat (3) @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    ena = 1'b1;
    abandon_last();
    repeat (20) @(negedge clk);
    chk_eq("abort_busy", o_busy, 0);
    chk_near("abort_phase_hold", int'(o_phase), last_phase, 4);
    chk_near("abort_fcw_hold", int'(o_fcw), last_fcw, 8);
    send(0, 0);
    send_random();

    for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clk);
    chk_eq("drain", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
